// File: rtl/tank_gfx_pkg.sv
// ----------------------------------------------------------------------------
// tank_gfx_pkg
// Shared sprite-graphics definitions for the tank, bullet and explosion
// renderers: facing-direction encoding, sprite box geometry, special palette
// indices and the ROM row address helper.
// No ports (package).
// ----------------------------------------------------------------------------
package tank_gfx_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   localparam int SPR_W      = 16;   // sprite box width in pixels
   localparam int SPR_H      = 8;    // sprite box height in pixels
   localparam int SPR_FRAMES = 4;    // one frame per direction
   localparam int ROM_ROWS   = SPR_H * SPR_FRAMES;

   localparam logic [5:0] TRANSPARENT_IDX = 6'd0;
   localparam logic [5:0] DEBUG_BOX_IDX   = 6'd63;

   // ROM row = dir*8 + row offset; with an 8-row frame that is a plain concat.
   function automatic logic [4:0] rom_row(input dir_t dir, input logic [2:0] dy);
      return {dir, dy};
   endfunction

endpackage

// File: rtl/bullet_hit_test.sv
// ----------------------------------------------------------------------------
// bullet_hit_test
// One bullet slot: holds the frame-buffered (shadow) copy of the slot state and
// performs the pipeline stage-1 box test of the current scan position.
// Ports:
//   clk_i, rst_i        pixel clock, synchronous active-high reset
//   latch_i             capture act_i/x_i/y_i/dir_i into the shadow set
//   act_i, x_i, y_i,    live slot state from game logic
//   dir_i
//   draw_x_i, draw_y_i  current scan position
//   hit_o               registered: position lies inside this slot's box
//   dx_o, dy_o          registered column / row offset inside the box
//   dir_o               registered shadow direction belonging to this test
// ----------------------------------------------------------------------------
module bullet_hit_test
   import tank_gfx_pkg::*;
#(
   parameter int COORD_W = 10
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               latch_i,
   input  logic               act_i,
   input  logic [COORD_W-1:0] x_i,
   input  logic [COORD_W-1:0] y_i,
   input  dir_t               dir_i,
   input  logic [COORD_W-1:0] draw_x_i,
   input  logic [COORD_W-1:0] draw_y_i,
   output logic               hit_o,
   output logic [3:0]         dx_o,
   output logic [2:0]         dy_o,
   output dir_t               dir_o
);

   // shadow set
   logic               act_q;
   logic [COORD_W-1:0] x_q;
   logic [COORD_W-1:0] y_q;
   dir_t               dir_q;

   // stage-1 registers
   logic       hit_q,  hit_d;
   logic [3:0] dx_q,   dx_d;
   logic [2:0] dy_q,   dy_d;
   dir_t       s1_dir_q;

   // One extra bit so a position left of / above the box shows up as a set
   // MSB instead of wrapping into a large positive offset.
   logic [COORD_W:0] diff_x;
   logic [COORD_W:0] diff_y;
   logic             in_x;
   logic             in_y;

   always_comb begin
      diff_x = {1'b0, draw_x_i} - {1'b0, x_q};
      diff_y = {1'b0, draw_y_i} - {1'b0, y_q};
      in_x   = !diff_x[COORD_W] && (diff_x[COORD_W-1:0] < COORD_W'(SPR_W));
      in_y   = !diff_y[COORD_W] && (diff_y[COORD_W-1:0] < COORD_W'(SPR_H));
      hit_d  = act_q && in_x && in_y;
      dx_d   = diff_x[3:0];
      dy_d   = diff_y[2:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         act_q    <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         dir_q    <= DIR_UP;
         hit_q    <= 1'b0;
         dx_q     <= '0;
         dy_q     <= '0;
         s1_dir_q <= DIR_UP;
      end else begin
         // The stage-1 compare above uses the pre-latch shadow, so a pixel
         // sampled on the latch edge still renders against the old frame.
         if (latch_i) begin
            act_q <= act_i;
            x_q   <= x_i;
            y_q   <= y_i;
            dir_q <= dir_i;
         end
         hit_q    <= hit_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         s1_dir_q <= dir_q;
      end
   end

   assign hit_o = hit_q;
   assign dx_o  = dx_q;
   assign dy_o  = dy_q;
   assign dir_o = s1_dir_q;

endmodule

// File: rtl/bullet_renderer.sv
// ----------------------------------------------------------------------------
// bullet_renderer
// Per scan pixel, decides whether an active bullet covers (DrawX,DrawY) and
// emits that bullet's palette index from the sprite ROM frame chosen by its
// direction. Bullet state is frame-buffered on frame_start. Latency 2 cycles:
//   S1 (in bullet_hit_test): per-slot box test, offsets, pix_valid registered
//   S2 (here): lowest-index opaque slot selected, ROM read, outputs registered
// Optional feature macro: BULLET_RENDER_DEBUG_BOX_EN -- transparent in-box
//   pixels of active slots are drawn with palette index 63.
// Ports:
//   Clk, Reset          pixel clock, synchronous active-high reset
//   frame_start         1-cycle pulse at start of vertical blank (latch)
//   b_active/x/y/dir    packed per-slot live state, slot 0 in the LSBs
//   sprite              sprite ROM, 32 rows x 16 cols of palette indices
//   pix_valid           DrawX/DrawY valid this cycle
//   DrawX, DrawY        current scan position
//   pix_hit, pix_idx    opaque bullet pixel flag and its palette index
//   frame_cnt           frames latched since reset, wraps
// ----------------------------------------------------------------------------
module bullet_renderer
   import tank_gfx_pkg::*;
#(
   parameter int N_BULLETS = 4,
   parameter int COORD_W   = 10,
   parameter int IDX_W     = 6
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_start,
   input  logic [N_BULLETS-1:0]           b_active,
   input  logic [N_BULLETS*COORD_W-1:0]   b_x,
   input  logic [N_BULLETS*COORD_W-1:0]   b_y,
   input  logic [N_BULLETS*2-1:0]         b_dir,
   input  logic [IDX_W-1:0]               sprite [0:ROM_ROWS-1][0:SPR_W-1],
   input  logic                           pix_valid,
   input  logic [COORD_W-1:0]             DrawX,
   input  logic [COORD_W-1:0]             DrawY,
   output logic                           pix_hit,
   output logic [IDX_W-1:0]               pix_idx,
   output logic [7:0]                     frame_cnt
);

   logic             slot_hit [N_BULLETS];
   logic [3:0]       slot_dx  [N_BULLETS];
   logic [2:0]       slot_dy  [N_BULLETS];
   dir_t             slot_dir [N_BULLETS];
   logic [IDX_W-1:0] rom_px   [N_BULLETS];

   logic             valid_s1_q;
   logic             hit_q, hit_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;

   for (genvar g = 0; g < N_BULLETS; g++) begin : g_slot
      bullet_hit_test #(
         .COORD_W (COORD_W)
      ) u_hit (
         .clk_i    (Clk),
         .rst_i    (Reset),
         .latch_i  (frame_start),
         .act_i    (b_active[g]),
         .x_i      (b_x[g*COORD_W +: COORD_W]),
         .y_i      (b_y[g*COORD_W +: COORD_W]),
         .dir_i    (dir_t'(b_dir[g*2 +: 2])),
         .draw_x_i (DrawX),
         .draw_y_i (DrawY),
         .hit_o    (slot_hit[g]),
         .dx_o     (slot_dx[g]),
         .dy_o     (slot_dy[g]),
         .dir_o    (slot_dir[g])
      );

      assign rom_px[g] = sprite[rom_row(slot_dir[g], slot_dy[g])][slot_dx[g]];
   end

   // Priority select: the lowest slot whose pixel is opaque wins; a slot that
   // covers the position with a transparent pixel lets the next one through.
   logic found;
   logic any_box;

   always_comb begin
      hit_d   = 1'b0;
      idx_d   = '0;
      found   = 1'b0;
      any_box = 1'b0;
      for (int i = 0; i < N_BULLETS; i++) begin
         if (slot_hit[i]) begin
            any_box = 1'b1;
            if (!found && (rom_px[i] != IDX_W'(TRANSPARENT_IDX))) begin
               found = 1'b1;
               hit_d = 1'b1;
               idx_d = rom_px[i];
            end
         end
      end
`ifdef BULLET_RENDER_DEBUG_BOX_EN
      if (!found && any_box) begin
         hit_d = 1'b1;
         idx_d = IDX_W'(DEBUG_BOX_IDX);
      end
`endif
      if (!valid_s1_q) begin
         hit_d = 1'b0;
         idx_d = '0;
      end
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_s1_q  <= 1'b0;
         hit_q       <= 1'b0;
         idx_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         valid_s1_q  <= pix_valid;
         hit_q       <= hit_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_hit   = hit_q;
   assign pix_idx   = idx_q;
   assign frame_cnt = frame_cnt_q;

endmodule
